// File: rtl/debouncer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : debouncer_if                                           |
// | Description : Sample strobe, raw inputs and debounced outputs of the |
// |               per-bit debouncer, bundled with master/slave views.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface debouncer_if #(
  parameter int WIDTH = 4
);
  logic             tick_in;
  logic [WIDTH-1:0] raw_in;
  logic [WIDTH-1:0] state_out;
  logic [WIDTH-1:0] rise_out;
  logic [WIDTH-1:0] fall_out;

  // Driver side: tick timer and raw inputs, consumes clean levels/strobes
  modport master (
    output tick_in,
    output raw_in,
    input  state_out,
    input  rise_out,
    input  fall_out
  );

  // Debouncer side
  modport slave (
    input  tick_in,
    input  raw_in,
    output state_out,
    output rise_out,
    output fall_out
  );
endinterface
`default_nettype wire

// File: rtl/debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : debouncer                                              |
// | Description : Per-bit debouncer. Raw inputs are synchronised, sampled|
// |               on each tick, and a bit flips after SAMPLES consecutive|
// |               disagreeing samples, with one-cycle rise/fall strobes. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module debouncer #(
  parameter int               WIDTH       = 4,
  parameter int               SAMPLES     = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic        clk_in,
  input  logic        reset_in,
  debouncer_if.slave  bus
);

  // Counter only needs to reach SAMPLES-1; width covers SAMPLES=1..255.
  localparam int             CNT_W    = $clog2(SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] state_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Two-flop synchroniser, free-running every cycle regardless of tick
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      sync1_q <= RESET_VALUE;
      sync2_q <= RESET_VALUE;
    end else begin
      sync1_q <= bus.raw_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit run-length count of disagreeing tick samples and flip decision
  always_comb begin
    state_d = state_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (bus.tick_in) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2_q[i] == state_q[i]) begin
          // Any agreeing sample breaks the run.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // This sample completes the run: flip and strobe in the same edge.
          state_d[i] = sync2_q[i];
          cnt_d[i]   = '0;
          rise_d[i]  = sync2_q[i];
          fall_d[i]  = ~sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounced level, strobes and counters; reset discards any partial count
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= RESET_VALUE;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.state_out = state_q;
  assign bus.rise_out  = rise_q;
  assign bus.fall_out  = fall_q;

endmodule
`default_nettype wire

// File: tb/tb_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_debouncer                                           |
// | Description : Self-checking bench for debouncer: cycle model feeding |
// |               a scoreboard queue plus directed checks.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_debouncer;

  localparam int WIDTH   = 4;
  localparam int SAMPLES = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             tick = 1'b0;
  logic [WIDTH-1:0] raw = '0;

  int n_vec = 0;
  int n_err = 0;

  debouncer_if #(.WIDTH(WIDTH)) dif ();

  assign dif.tick_in = tick;
  assign dif.raw_in  = raw;

  debouncer #(
    .WIDTH       (WIDTH),
    .SAMPLES     (SAMPLES),
    .RESET_VALUE (4'h0)
  ) u_dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (dif.slave)
  );

  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: synchroniser pipeline plus a run length per bit.
  logic [WIDTH-1:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_rise = '0, m_fall = '0;
  int               m_run [WIDTH];
  logic [3*WIDTH-1:0] sb_q [$];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
    end else begin
      m_rise = '0;
      m_fall = '0;
      if (tick) begin
        for (int i = 0; i < WIDTH; i++) begin
          if (m_s2[i] !== m_state[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == SAMPLES) begin
              m_state[i] = m_s2[i];
              m_run[i]   = 0;
              if (m_s2[i]) m_rise[i] = 1'b1;
              else         m_fall[i] = 1'b1;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
    sb_q.push_back({m_state, m_rise, m_fall});
  end

  // Scoreboard: compare what the DUT registered at the last edge
  always @(negedge clk) begin
    logic [3*WIDTH-1:0] e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_val("sb_state", dif.state_out, e[3*WIDTH-1:2*WIDTH]);
      chk_val("sb_rise",  dif.rise_out,  e[2*WIDTH-1:WIDTH]);
      chk_val("sb_fall",  dif.fall_out,  e[WIDTH-1:0]);
    end
  end

  // One tick period: gap idle cycles then a one-cycle tick; returns at the
  // negedge following the tick edge so its effect is visible.
  task automatic tick_once(input int gap);
    repeat (gap) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick_once(7);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
    chk_val({tag, "_state"}, dif.state_out, s);
    chk_val({tag, "_rise"},  dif.rise_out,  r);
    chk_val({tag, "_fall"},  dif.fall_out,  f);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset with inputs high
    raw = 4'hF;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_out("rst", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_once(7);
      chk_out("t1_pre", 4'h0, 4'h0, 4'h0);
    end
    tick_once(7);
    chk_out("t1_flip", 4'hF, 4'hF, 4'h0);
    @(negedge clk);
    chk_out("t1_after", 4'hF, 4'h0, 4'h0);
    raw = 4'h0;
    ticks(4);
    chk_out("t1_back", 4'h0, 4'h0, 4'hF);

    // 2: bounce rejection on bit 0
    raw = 4'b0001;
    ticks(3);
    raw = 4'b0000;
    tick_once(7);
    chk_out("t2_bounce", 4'h0, 4'h0, 4'h0);
    raw = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick_once(7);
      chk_out("t2_pre", 4'h0, 4'h0, 4'h0);
    end
    tick_once(7);
    chk_out("t2_flip", 4'b0001, 4'b0001, 4'h0);
    @(negedge clk);
    chk_out("t2_after", 4'b0001, 4'h0, 4'h0);

    // 3: simultaneous rise and fall
    raw = 4'b0100;
    ticks(4);
    chk_out("t3_setup", 4'b0100, 4'b0100, 4'b0001);
    raw = 4'b0010;
    ticks(4);
    chk_out("t3_flip", 4'b0010, 4'b0010, 4'b0100);
    @(negedge clk);
    chk_out("t3_after", 4'b0010, 4'h0, 4'h0);

    // 4: reset mid-count, tick high during reset
    raw = 4'b1010;
    ticks(3);
    rst  = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    tick = 1'b0;
    chk_out("t4_rst", 4'h0, 4'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      tick_once(7);
      chk_out("t4_pre", 4'h0, 4'h0, 4'h0);
    end
    tick_once(7);
    chk_out("t4_flip", 4'b1010, 4'b1010, 4'h0);

    // 5: continuous tick, bit 1 rises 2+SAMPLES edges after raw change
    raw = 4'b0000;
    ticks(4);
    chk_out("t5_setup", 4'h0, 4'h0, 4'b1010);
    @(negedge clk);
    tick = 1'b1;
    raw  = 4'b0010;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k < 6)       chk_out("t5_wait", 4'h0, 4'h0, 4'h0);
      else if (k == 6) chk_out("t5_flip", 4'b0010, 4'b0010, 4'h0);
      else             chk_out("t5_hold", 4'b0010, 4'h0, 4'h0);
    end
    tick = 1'b0;

    // 6: idle hold for 100 ticks
    for (int k = 0; k < 100; k++) begin
      tick_once(7);
      chk_out("t6_idle", 4'b0010, 4'h0, 4'h0);
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
